// File: rtl/add_accum.sv
// add_accum: registered signed adder/subtractor with valid/ready handshake
// and optional K-beat burst accumulation.
//
// Each accepted beat forms T = X +/- Y exactly in n+1 bits. In single mode T
// is emitted as one result. In accumulate mode K consecutive terms are summed
// at full precision (W bits) and emitted as one result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_valid   X/Y/sub/acc_en valid this cycle
//   in_ready   block accepts a beat this cycle (combinational)
//   X, Y       signed n-bit operands
//   sub        per beat: 0 -> X+Y, 1 -> X-Y
//   acc_en     sampled on the first beat of a burst: 0 single, 1 accumulate K
//   out_valid  S holds a result
//   out_ready  downstream consumes S this cycle
//   S          signed W-bit result
//   busy       accumulation burst in progress
module add_accum #(
    parameter int n = 4,
    parameter int K = 4,
    localparam int unsigned W = n + 1 + $clog2(K)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [n-1:0] X,
    input  logic signed [n-1:0] Y,
    input  logic                sub,
    input  logic                acc_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] S,
    output logic                busy
);

    // Counter must be at least one bit wide even when K == 1.
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned TW = n + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t                state;
    logic signed [W-1:0]   acc;
    logic [CW-1:0]         cnt;

    logic signed [TW-1:0]  x_ext;
    logic signed [TW-1:0]  y_ext;
    logic signed [TW-1:0]  term;
    logic signed [W-1:0]   term_w;
    logic                  acc_beat;
    logic                  last_beat;

    // Upstream may push whenever the output slot is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign acc_beat = in_valid && in_ready;

    // Signed size casts sign-extend, so T is exact and widens without wrap.
    assign x_ext  = TW'(X);
    assign y_ext  = TW'(Y);
    assign term   = sub ? (x_ext - y_ext) : (x_ext + y_ext);
    assign term_w = W'(term);

    assign last_beat = (cnt == CW'(K - 1));

    assign busy = (state == ACC);

    // Burst FSM, accumulator and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            S         <= '0;
            out_valid <= 1'b0;
        end else begin
            // Drain first; a result loaded below on this same edge wins.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (acc_beat) begin
                case (state)
                    IDLE: begin
                        if (acc_en && (K > 1)) begin
                            acc   <= term_w;
                            cnt   <= CW'(1);
                            state <= ACC;
                        end else begin
                            S         <= term_w;
                            out_valid <= 1'b1;
                        end
                    end
                    ACC: begin
                        if (last_beat) begin
                            S         <= acc + term_w;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= IDLE;
                        end else begin
                            acc <= acc + term_w;
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_add_accum.sv
// tb_add_accum: self-checking bench for add_accum (n=4, K=4, W=7).
// Directed scenarios followed by a randomized phase, all checked against a
// behavioural integer model of the handshake and burst-summing rules.
module tb_add_accum;

    localparam int N  = 4;
    localparam int KK = 4;
    localparam int WW = 7;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [N-1:0]  X;
    logic signed [N-1:0]  Y;
    logic                 sub;
    logic                 acc_en;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [WW-1:0] S;
    logic                 busy;

    int tests;
    int fails;

    // Reference model state
    bit m_ov;
    int m_s;
    int m_terms;
    int m_sum;

    add_accum #(.n(N), .K(KK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .sub       (sub),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_in(input bit v, input int x, input int y, input bit s,
                          input bit a, input bit ordy);
        in_valid  = v;
        X         = 4'(x);
        Y         = 4'(y);
        sub       = s;
        acc_en    = a;
        out_ready = ordy;
    endtask

    // Apply the specification's rules for one clock edge to the model.
    task automatic model_step();
        bit rdy;
        bit got;
        int res;
        int t;
        rdy = !m_ov || out_ready;
        got = 1'b0;
        res = 0;
        if (rst) begin
            m_ov = 1'b0; m_s = 0; m_terms = 0; m_sum = 0;
        end else begin
            if (in_valid && rdy) begin
                t = sub ? (int'(X) - int'(Y)) : (int'(X) + int'(Y));
                if (m_terms == 0 && !(acc_en && KK > 1)) begin
                    got = 1'b1; res = t;
                end else begin
                    m_sum   += t;
                    m_terms += 1;
                    if (m_terms == KK) begin
                        got = 1'b1; res = m_sum; m_sum = 0; m_terms = 0;
                    end
                end
            end
            if (got) begin
                m_ov = 1'b1; m_s = res;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
        end
    endtask

    // One clock: check in_ready before the edge, outputs just after it.
    task automatic tick(input string tag);
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(!m_ov || out_ready));
        model_step();
        @(posedge clk);
        #1;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({tag, "_S"}, 32'(S), m_s);
        chk({tag, "_busy"}, 32'(busy), 32'(m_terms != 0));
    endtask

    initial begin
        tests = 0; fails = 0;
        m_ov = 1'b0; m_s = 0; m_terms = 0; m_sum = 0;
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        @(posedge clk);

        // Reset state
        tick("reset");
        chk("reset_S_zero", 32'(S), 0);
        chk("reset_ov_zero", 32'(out_valid), 0);
        rst = 1'b0;

        // 1. single add of max positives
        set_in(1, 7, 7, 0, 0, 1); tick("add77");
        chk("add77_const", 32'(S), 14);
        // 2. single sub and add of most negatives, back to back
        set_in(1, -8, 7, 1, 0, 1); tick("sub_m8_7");
        chk("sub_m8_7_const", 32'(S), -15);
        chk("b2b_ov", 32'(out_valid), 1);
        set_in(1, -8, -8, 0, 0, 1); tick("add_m8m8");
        chk("add_m8m8_const", 32'(S), -16);
        set_in(0, 0, 0, 0, 0, 1); tick("drain1");

        // 3. full negative burst
        set_in(1, -8, -8, 0, 1, 1); tick("burst_b1");
        chk("burst_b1_busy", 32'(busy), 1);
        set_in(1, -8, -8, 0, 0, 1); tick("burst_b2");
        tick("burst_b3");
        chk("burst_b3_noov", 32'(out_valid), 0);
        tick("burst_b4");
        chk("burst_S_const", 32'(S), -64);
        chk("burst_busy_end", 32'(busy), 0);

        // 4. backpressure holds S and blocks input
        set_in(1, 5, 5, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick("stall");
        chk("stall_S_const", 32'(S), -64);
        chk("stall_in_ready", 32'(in_ready), 0);
        set_in(1, 1, 2, 0, 0, 1); tick("release");
        chk("release_S_const", 32'(S), 3);
        chk("release_ov", 32'(out_valid), 1);

        // 5. reset mid-burst, then a clean burst
        set_in(1, 1, 0, 0, 1, 1); tick("rb1");
        set_in(1, 1, 0, 0, 0, 1); tick("rb2");
        rst = 1'b1; tick("mid_rst");
        chk("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        set_in(1, 1, 0, 0, 1, 1); tick("nb1");
        set_in(1, 1, 0, 0, 0, 1); tick("nb2"); tick("nb3"); tick("nb4");
        chk("nb_S_const", 32'(S), 4);

        // 6. mixed sub with acc_en low after the first beat and idle gaps
        set_in(1, 3, 1, 0, 1, 1); tick("mx1");
        set_in(0, 0, 0, 0, 0, 1); tick("mx_gap1"); tick("mx_gap2");
        set_in(1, 3, 1, 1, 0, 1); tick("mx2");
        set_in(1, -2, 5, 0, 0, 1); tick("mx3");
        chk("mx3_busy", 32'(busy), 1);
        set_in(1, 0, -8, 1, 0, 1); tick("mx4");
        chk("mx_S_const", 32'(S), 17);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            set_in($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 2) != 0);
            tick("rand");
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
